// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared opcodes, control encodings and types for the multi-cycle RV32I control FSM.
package mc_ctrl_fsm_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_S = 3'd1;
  localparam logic [2:0] EXT_B = 3'd2;
  localparam logic [2:0] EXT_J = 3'd3;
  localparam logic [2:0] EXT_U = 3'd4;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic lui;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic illegal;
  } ins_cls_t;

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Unified memory request port shared by instruction fetch and load/store.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_rdy;

  modport master (output mem_req, output mem_we, input mem_rdy);
  modport slave  (input mem_req, input mem_we, output mem_rdy);
endinterface

// File: rtl/mc_ctrl_fsm_dec.sv
// Combinational instruction-class decode: class flags, ALUOp, EXTOp and ALUSrc from IR fields.
module mc_ctrl_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output ins_cls_t   cls_o,
  output logic [4:0] alu_op_o,
  output logic [2:0] ext_op_o,
  output logic       alu_src_o
);

  always_comb begin
    cls_o     = '0;
    alu_op_o  = ALU_ADD;
    ext_op_o  = EXT_I;
    alu_src_o = 1'b0;
    unique case (op_i)
      OP_RTYPE: begin
        cls_o.rtype = 1'b1;
        if (funct7_i == F7_SUB && funct3_i == F3_ADD) alu_op_o = ALU_SUB;
      end
      OP_ITYPE: begin
        cls_o.itype = 1'b1;
        alu_src_o   = 1'b1;
      end
      OP_LUI: begin
        cls_o.lui = 1'b1;
        ext_op_o  = EXT_U;
        alu_src_o = 1'b1;
      end
      OP_LOAD: begin
        cls_o.load = 1'b1;
        alu_src_o  = 1'b1;
      end
      OP_STORE: begin
        cls_o.store = 1'b1;
        ext_op_o    = EXT_S;
        alu_src_o   = 1'b1;
      end
      OP_BRANCH: begin
        cls_o.branch = 1'b1;
        ext_op_o     = EXT_B;
        alu_op_o     = ALU_SUB;
      end
      OP_JAL: begin
        cls_o.jal = 1'b1;
        ext_op_o  = EXT_J;
      end
      OP_JALR: begin
        cls_o.jalr = 1'b1;
        alu_src_o  = 1'b1;
      end
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP with an illegal output.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned RST_IDLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  mc_ctrl_fsm_if.master    mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic             RegWrite,
  output logic [2:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic             ALUSrc,
  output logic [2:0]       DMType,
  output logic [1:0]       WDSel,
  output logic [1:0]       NPCOp,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic             instr_done
);

  localparam int unsigned CW = (RST_IDLE_CYC > 1) ? $clog2(RST_IDLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_IDLE_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  ins_cls_t   cls;
  logic [4:0] dec_alu_op;
  logic [2:0] dec_ext_op;
  logic       dec_alu_src;
  logic       mem_req_c, mem_we_c;

  mc_ctrl_dec u_dec (
    .op_i      (Op),
    .funct7_i  (Funct7),
    .funct3_i  (Funct3),
    .cls_o     (cls),
    .alu_op_o  (dec_alu_op),
    .ext_op_o  (dec_ext_op),
    .alu_src_o (dec_alu_src)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FETCH:  if (mem.mem_rdy) state_d = DECODE;
      DECODE: begin
        if (cls.illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          state_d = WB;
`endif
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls.load || cls.store)                                  state_d = MEM;
        else if (cls.branch)                                        state_d = FETCH;
        else if (cls.rtype || cls.itype || cls.lui || cls.jal || cls.jalr) state_d = WB;
        else                                                        state_d = FETCH;
      end
      MEM: if (mem.mem_rdy) state_d = cls.store ? FETCH : WB;
      WB:     state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from the state register; mem_rdy only gates the completion strobes.
  always_comb begin
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    RegWrite   = 1'b0;
    EXTOp      = EXT_I;
    ALUOp      = '0;
    ALUSrc     = 1'b0;
    DMType     = '0;
    WDSel      = WD_ALU;
    NPCOp      = NPC_PC4;
    instr_done = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    unique case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        ir_we     = mem.mem_rdy;
      end
      DECODE: begin
        EXTOp  = dec_ext_op;
        ALUSrc = dec_alu_src;
      end
      EXEC: begin
        EXTOp  = dec_ext_op;
        ALUSrc = dec_alu_src;
        ALUOp  = dec_alu_op;
        if (cls.branch) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          NPCOp      = branch_taken(Funct3, Zero) ? NPC_BR : NPC_PC4;
        end
      end
      MEM: begin
        EXTOp     = dec_ext_op;
        ALUSrc    = dec_alu_src;
        mem_req_c = 1'b1;
        mem_we_c  = cls.store;
        DMType    = Funct3;
        if (cls.store && mem.mem_rdy) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
      end
      WB: begin
        EXTOp      = dec_ext_op;
        ALUSrc     = dec_alu_src;
        RegWrite   = !cls.illegal;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (cls.load)                 WDSel = WD_MEM;
        else if (cls.jal || cls.jalr) WDSel = WD_PC4;
        if (cls.jal)                  NPCOp = NPC_JAL;
        else if (cls.jalr)            NPCOp = NPC_JALR;
      end
      TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control vectors for each instruction class.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;
  logic       Zero;
  logic       ir_we, pc_we, RegWrite, ALUSrc, instr_done;
  logic [2:0] EXTOp, DMType;
  logic [4:0] ALUOp;
  logic [1:0] WDSel, NPCOp;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  mc_ctrl_fsm_if mem_if ();

  mc_ctrl_fsm #(.RST_IDLE_CYC(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .Op         (Op),
    .Funct7     (Funct7),
    .Funct3     (Funct3),
    .Zero       (Zero),
    .mem        (mem_if),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .RegWrite   (RegWrite),
    .EXTOp      (EXTOp),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .DMType     (DMType),
    .WDSel      (WDSel),
    .NPCOp      (NPCOp),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, ir_we, pc_we, RegWrite, instr_done, EXTOp, ALUOp, ALUSrc, DMType, WDSel, NPCOp}
  logic [21:0] obs;
  assign obs = {mem_if.mem_req, mem_if.mem_we, ir_we, pc_we, RegWrite, instr_done,
                EXTOp, ALUOp, ALUSrc, DMType, WDSel, NPCOp};

  function automatic logic [21:0] ev(input int mr, input int mw, input int iw, input int pw,
                                     input int rw, input int dn, input int ext, input int alu,
                                     input int src, input int dm, input int wd, input int npc);
    return {1'(mr), 1'(mw), 1'(iw), 1'(pw), 1'(rw), 1'(dn), 3'(ext), 5'(alu), 1'(src),
            3'(dm), 2'(wd), 2'(npc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; Op = '0; Funct7 = '0; Funct3 = '0; Zero = 1'b0; mem_if.mem_rdy = 1'b0;
    #2 rstn = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 22'd0); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
`endif
    rstn = 1'b1;
    #1;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, 22'd0); end
    tick();
    checks++;
    if (obs !== ev(1,0,0,0,0,0,0,0,0,0,0,0)) begin
      errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask

  // Four-cycle F/D/E/W instructions; memory answers immediately.
  task automatic test_exec_wb(input string name, input logic [6:0] op, input logic [6:0] f7,
                              input logic [2:0] f3, input int ext, input int alu, input int src,
                              input int wd, input int npc);
    logic [21:0] e [4];
    Op = op; Funct7 = f7; Funct3 = f3;
    e[0] = ev(1,0,1,0,0,0,0,  0,  0,  0,0, 0);
    e[1] = ev(0,0,0,0,0,0,ext,0,  src,0,0, 0);
    e[2] = ev(0,0,0,0,0,0,ext,alu,src,0,0, 0);
    e[3] = ev(0,0,0,1,1,1,ext,0,  src,0,wd,npc);
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_rdy = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", name, i, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_branch(input string name, input logic [2:0] f3, input logic z, input int npc);
    logic [21:0] e [3];
    Op = 7'b1100011; Funct7 = '0; Funct3 = f3; Zero = z;
    e[0] = ev(1,0,1,0,0,0,0,0,0,0,0,0);
    e[1] = ev(0,0,0,0,0,0,2,0,0,0,0,0);
    e[2] = ev(0,0,0,1,0,1,2,4,0,0,0,npc);
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_rdy = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", name, i, obs, e[i]); end
      tick();
    end
    Zero = 1'b0;
  endtask

  // lw with memory stalling three cycles in MEM; mem_rdy high in DECODE/EXEC must be ignored.
  task automatic test_load();
    logic [21:0] e [8];
    logic        r [8];
    Op = 7'b0000011; Funct7 = '0; Funct3 = 3'b010;
    e[0] = ev(1,0,1,0,0,0,0,0,0,0,0,0); r[0] = 1'b1;
    e[1] = ev(0,0,0,0,0,0,0,0,1,0,0,0); r[1] = 1'b1;
    e[2] = ev(0,0,0,0,0,0,0,3,1,0,0,0); r[2] = 1'b1;
    e[3] = ev(1,0,0,0,0,0,0,0,1,2,0,0); r[3] = 1'b0;
    e[4] = ev(1,0,0,0,0,0,0,0,1,2,0,0); r[4] = 1'b0;
    e[5] = ev(1,0,0,0,0,0,0,0,1,2,0,0); r[5] = 1'b0;
    e[6] = ev(1,0,0,0,0,0,0,0,1,2,0,0); r[6] = 1'b1;
    e[7] = ev(0,0,0,1,1,1,0,0,1,0,1,0); r[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_if.mem_rdy = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL lw[%0d]: got %h expected %h", i, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [21:0] e [5];
    logic        r [5];
    Op = 7'b0100011; Funct7 = '0; Funct3 = 3'b010;
    e[0] = ev(1,0,1,0,0,0,0,0,0,0,0,0); r[0] = 1'b1;
    e[1] = ev(0,0,0,0,0,0,1,0,1,0,0,0); r[1] = 1'b0;
    e[2] = ev(0,0,0,0,0,0,1,3,1,0,0,0); r[2] = 1'b0;
    e[3] = ev(1,1,0,0,0,0,1,0,1,2,0,0); r[3] = 1'b0;
    e[4] = ev(1,1,0,1,0,1,1,0,1,2,0,0); r[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_rdy = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL sw[%0d]: got %h expected %h", i, obs, e[i]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_fetch();
    Op = 7'b0110011; Funct7 = '0; Funct3 = '0;
    for (int i = 0; i < 2; i++) begin
      mem_if.mem_rdy = 1'b0;
      #1;
      checks++;
      if (obs !== ev(1,0,0,0,0,0,0,0,0,0,0,0)) begin
        errors++; $display("FAIL fetch_wait[%0d]: got %h expected %h", i, obs, ev(1,0,0,0,0,0,0,0,0,0,0,0));
      end
      tick();
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: got %b expected 0", mem_if.mem_req); end
    tick(); tick();
    rstn = 1'b1;
    mem_if.mem_rdy = 1'b1;
    #1;
    checks++;
    if (obs !== 22'd0) begin errors++; $display("FAIL restart_idle: got %h expected %h", obs, 22'd0); end
    tick();
    checks++;
    if (obs !== ev(1,0,1,0,0,0,0,0,0,0,0,0)) begin
      errors++; $display("FAIL restart_fetch: got %h expected %h", obs, ev(1,0,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e [4];
    Op = 7'b1111111; Funct7 = '0; Funct3 = '0;
    e[0] = ev(1,0,1,0,0,0,0,0,0,0,0,0);
    e[1] = ev(0,0,0,0,0,0,0,0,0,0,0,0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    e[2] = ev(0,0,0,0,0,0,0,0,0,0,0,0);
    e[3] = ev(0,0,0,0,0,0,0,0,0,0,0,0);
`else
    e[2] = ev(0,0,0,1,0,1,0,0,0,0,0,0);
    e[3] = ev(1,0,1,0,0,0,0,0,0,0,0,0);
`endif
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_rdy = 1'b1;
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL illegal_op[%0d]: got %h expected %h", i, obs, e[i]); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== (i >= 2)) begin errors++; $display("FAIL illegal_flag[%0d]: got %b expected %b", i, illegal, (i >= 2)); end
`endif
      tick();
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    rstn = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL trap_reset: got %b expected 0", illegal); end
    rstn = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_exec_wb("add",  7'b0110011, 7'b0000000, 3'b000, 0, 3, 0, 0, 0);
    test_exec_wb("sub",  7'b0110011, 7'b0100000, 3'b000, 0, 4, 0, 0, 0);
    test_exec_wb("addi", 7'b0010011, 7'b0000000, 3'b000, 0, 3, 1, 0, 0);
    test_exec_wb("lui",  7'b0110111, 7'b0000000, 3'b000, 4, 3, 1, 0, 0);
    test_exec_wb("jal",  7'b1101111, 7'b0000000, 3'b000, 3, 3, 0, 2, 2);
    test_exec_wb("jalr", 7'b1100111, 7'b0000000, 3'b000, 0, 3, 1, 2, 3);
    test_branch("beq_taken",     3'b000, 1'b1, 1);
    test_branch("beq_not_taken", 3'b000, 1'b0, 0);
    test_branch("bne_not_taken", 3'b001, 1'b1, 0);
    test_branch("bne_taken",     3'b001, 1'b0, 1);
    test_branch("blt_not_taken", 3'b100, 1'b0, 0);
    test_load();
    test_store();
    test_reset_mid_fetch();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath; replaces single-cycle combinational decode with a state machine stepping FETCH/DECODE/EXEC/MEM/WB.
- Drives IR/PC/RF/memory strobes and per-state mux selects.
- Owns the single unified memory request port (req/rdy handshake) shared by instruction fetch and load/store.
- Sits between the instruction register, ALU (Zero flag) and data/instruction memory.

Parameters:
- RST_IDLE_CYC, 1, cycles spent in IDLE after reset release before the first fetch (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- Op  in  7  IR[6:0]
- Funct7  in  7  IR[31:25]
- Funct3  in  3  IR[14:12]
- Zero  in  1  ALU zero flag, valid in EXEC
- mem_rdy  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_rdy
- mem_we  out  1  store request (valid with mem_req)
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC with the NPCOp-selected value
- RegWrite  out  1  register file write
- EXTOp  out  3  0=I, 1=S, 2=B, 3=J, 4=U
- ALUOp  out  5  5'b00011 add, 5'b00100 sub
- ALUSrc  out  1  ALU B operand: 0=rs2, 1=immediate
- DMType  out  3  equals Funct3 during MEM, else 0
- WDSel  out  2  0=ALU, 1=memory, 2=PC+4
- NPCOp  out  2  0=PC+4, 1=branch target, 2=JAL, 3=JALR
- instr_done  out  1  one-cycle pulse, coincident with the final pc_we

Behaviour:
- Reset (rstn low, async): state=IDLE; all outputs 0; IDLE counter cleared.
- IDLE: count RST_IDLE_CYC cycles, then go to FETCH.
- FETCH: mem_req=1, mem_we=0. When mem_rdy is high, pulse ir_we and go to DECODE. Without mem_rdy, stay in FETCH with all outputs stable.
- DECODE: one cycle, no strobes; EXTOp and ALUSrc are valid from this state onward.
- EXEC, by instruction class:
  - R-type / I-ALU: ALUOp per decode, go to WB.
  - Load/store: ALUOp=add, ALUSrc=1, go to MEM.
  - Branch: ALUOp=sub. Taken = (beq & Zero) | (bne & !Zero); other Funct3 values are not taken. Assert pc_we with NPCOp=1 if taken, else 0. Pulse instr_done, go to FETCH.
  - JAL/JALR: go to WB.
- MEM: mem_req=1, mem_we=store. On mem_rdy, a load goes to WB; a store asserts pc_we (NPCOp=0) and instr_done and goes to FETCH.
- WB: one cycle.
  - RegWrite=1.
  - WDSel: 1 for load, 2 for JAL/JALR, else 0.
  - NPCOp: 2 for JAL, 3 for JALR, else 0.
  - pc_we=1 and instr_done=1, then go to FETCH.
- Latency with mem_rdy high immediately: branch 3, store 4, R/I/JAL/JALR 4, load 5 cycles.
- Exactly one pc_we per instruction; RegWrite never in the same cycle as mem_req.
- Outputs are a combinational function of the state register and IR fields. mem_rdy qualifies only ir_we, and the pc_we/instr_done pulses in MEM.
- mem_rdy high outside FETCH/MEM: ignored.
- Reset mid-request: mem_req drops asynchronously; FSM restarts from IDLE.
- Unknown opcode: treated as NOP; DECODE goes directly to WB with RegWrite forced 0, pc_we=1, NPCOp=0.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit). An unknown opcode enters state TRAP, which asserts illegal=1 and holds all other outputs at 0 until reset.
- Undefined: no illegal port; unknown opcode is handled as the NOP above.

Decomposition:
- Shared package holds:
  - opcode constants (7'b0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111)
  - EXTOp, ALUOp, WDSel, NPCOp encodings
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP)
- One natural sub-module, mc_ctrl_dec: pure combinational instruction-class decode (rtype/itype/load/store/branch/jal/jalr/illegal, ALUOp, EXTOp). The FSM instantiates it.

Test Plan:
- Reset, then mem_rdy tied 1: IDLE for 1 cycle; FETCH asserts mem_req and ir_we; sequence F,D,E,W for add (Op=0110011, F7=0) gives RegWrite=1, WDSel=0, ALUOp=00011, pc_we with NPCOp=0.
- beq with Zero=1: pc_we=1, NPCOp=1 in EXEC, total 3 cycles. bne with Zero=1: pc_we=1, NPCOp=0.
- lw (Op=0000011, F3=010) with mem_rdy delayed 3 cycles in MEM: mem_req held 4 cycles, DMType=010, then WB with WDSel=1, RegWrite=1.
- sw (Op=0100011): EXTOp=1, mem_we=1 in MEM, no RegWrite; instr_done on the mem_rdy cycle.
- jalr (Op=1100111): WB has WDSel=2, NPCOp=3, RegWrite=1. jal: EXTOp=3, NPCOp=2.
- rstn low during FETCH wait: mem_req drops immediately, state returns to IDLE. Op=7'b1111111 gives NOP (or TRAP with illegal=1 under MC_CTRL_ILLEGAL_TRAP_EN).
